stk_ptr_alloc: RTL
==================

Name: stk_ptr_alloc

Overview:
- Free-list allocator for the stack pipeline's pointer space, one instance per stack.
- Supplies the pointer consumed by the lookup stage on PUSH and reclaims pointers released on POP/INV.
- Tracks in-use status per pointer and flags protocol errors.
- Sits beside the lookup stage and drives its allocation pointer input.

Parameters:
- PTR_W, 3 (set to stk_pkg::PTR_W in the system): pointer width.
- PTRS_N, 1 << PTR_W: number of managed pointers. Must be a power of two.
- LOW_WM, 2: low-watermark threshold on the free count.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset; synchronous, active-low.
- o_busy  out  1  initialisation walk in progress.
- o_alloc_vld  out  1  a free pointer is offered.
- o_alloc_ptr  out  PTR_W  offered pointer; valid when o_alloc_vld=1.
- i_alloc_ack  in  1  consumer takes the offered pointer this cycle.
- i_free_vld  in  1  pointer release request.
- i_free_ptr  in  PTR_W  pointer being released.
- o_free_cnt  out  PTR_W+1  number of free pointers.
- o_low  out  1  registered flag: o_free_cnt < LOW_WM.
- o_err_uflow  out  1  sticky: i_alloc_ack seen while o_alloc_vld=0.
- o_err_oflow  out  1  sticky: free seen while o_free_cnt == PTRS_N.
- o_err_dbl_free  out  1  sticky: free of a pointer not currently in use.

Behaviour:
- Storage:
  - Circular FIFO fifo[PTRS_N] of PTR_W bits with rd_idx/wr_idx of PTR_W bits (natural wrap) and count of PTR_W+1 bits.
  - In-use bitmap used[PTRS_N].
- Reset (arst_n=0 at a clk edge), including mid-operation:
  - FSM state = INIT; init_idx, rd_idx, wr_idx, count = 0; used = all 0.
  - Sticky errors = 0; o_low = 1.
  - Any in-flight request is discarded.
- FSM INIT:
  - Each cycle: fifo[wr_idx] = init_idx; wr_idx++, init_idx++, count++.
  - On writing init_idx == PTRS_N-1, go to RUN. INIT lasts exactly PTRS_N cycles.
  - o_busy = 1 throughout INIT, 0 in RUN.
  - o_alloc_vld = 0; i_alloc_ack and i_free_vld are ignored, with no error flagged.
- FSM RUN:
  - Never leaves RUN except via reset.
  - o_alloc_vld = (count != 0); o_alloc_ptr = fifo[rd_idx] (combinational read of the flop array).
- Allocation, when i_alloc_ack & o_alloc_vld:
  - rd_idx++, count--, used[o_alloc_ptr] = 1.
- Underflow, when i_alloc_ack & ~o_alloc_vld in RUN:
  - No state change; o_err_uflow = 1 next cycle.
- Free, when i_free_vld in RUN:
  - Checks are evaluated in this priority order.
  - If count == PTRS_N (before this cycle's ack): drop; o_err_oflow = 1.
  - Else if used[i_free_ptr] == 0: drop; o_err_dbl_free = 1.
  - Else: fifo[wr_idx] = i_free_ptr; wr_idx++, count++, used[i_free_ptr] = 0.
- Simultaneous valid alloc and valid free:
  - Both are performed; count is unchanged.
  - If i_free_ptr equals the pointer allocated this cycle: it was not in use before this cycle, so the free is a double-free and is dropped. The allocation still completes.
- No bypass:
  - A pointer freed in cycle t is first offerable in cycle t+1.
  - When count == 0, a free in cycle t raises o_alloc_vld in t+1.
- Outputs:
  - o_free_cnt = count (combinational from the register); during INIT it ramps 0..PTRS_N.
  - o_low is registered: updated each cycle to (next count < LOW_WM).
  - Error flags are registered and clear only on reset.
- Wrap-around: rd_idx and wr_idx wrap modulo PTRS_N naturally. count disambiguates full from empty (rd_idx == wr_idx in both cases).
- Allocation order is FIFO: after init, pointers are handed out 0,1,...,PTRS_N-1, then in freed order.

Test Plan:
- Reset, then idle (PTR_W=3):
  - o_busy = 1 for 8 cycles, then 0.
  - o_free_cnt ramps 0..8, then holds 8.
  - o_alloc_vld = 1 with o_alloc_ptr = 0; o_low = 0; all errors 0.
- Ack 8 consecutive cycles after init:
  - ptrs 0..7 handed out in order; o_free_cnt 8 -> 0.
  - o_low rises once count < 2; o_alloc_vld = 0 after the 8th ack.
  - A 9th ack sets o_err_uflow = 1.
- With count = 0:
  - free ptr 5 -> next cycle o_alloc_vld = 1, o_alloc_ptr = 5, o_free_cnt = 1.
  - Freeing 5 again -> o_err_dbl_free = 1, o_free_cnt stays 1.
- Steady state at count = 3:
  - ack plus free of a previously allocated ptr in the same cycle -> o_free_cnt stays 3.
  - The freed ptr appears at o_alloc_ptr after the 3 older entries.
- Full pool (count = 8):
  - free of any ptr -> o_err_oflow = 1, o_free_cnt stays 8, FIFO unchanged.
- Reset asserted mid-RUN (count = 2, errors set):
  - Next cycle o_busy = 1, o_free_cnt = 0, errors = 0, o_alloc_vld = 0.
  - Full 8-cycle re-init; allocation restarts at ptr 0.

Source files
------------

// File: rtl/stk_ptr_alloc.sv
// Free-list pointer allocator for one stack: circular FIFO of free pointers,
// per-pointer in-use bitmap, low-watermark flag and sticky protocol error flags.
module stk_ptr_alloc #(
    parameter int PTR_W  = 3,
    parameter int PTRS_N = 1 << PTR_W,
    parameter int LOW_WM = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    output logic             o_busy,
    output logic             o_alloc_vld,
    output logic [PTR_W-1:0] o_alloc_ptr,
    input  logic             i_alloc_ack,
    input  logic             i_free_vld,
    input  logic [PTR_W-1:0] i_free_ptr,
    output logic [PTR_W:0]   o_free_cnt,
    output logic             o_low,
    output logic             o_err_uflow,
    output logic             o_err_oflow,
    output logic             o_err_dbl_free
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(PTRS_N);
    localparam logic [PTR_W:0]   LOW_CNT  = (PTR_W + 1)'(LOW_WM);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PTRS_N - 1);

    state_t              state_q;
    logic [PTR_W-1:0]    fifo_q [PTRS_N];
    logic [PTR_W-1:0]    rd_idx_q;
    logic [PTR_W-1:0]    wr_idx_q;
    logic [PTR_W-1:0]    init_idx_q;
    logic [PTR_W:0]      count_q;
    logic [PTR_W:0]      count_d;
    logic [PTRS_N-1:0]   used_q;
    logic [PTRS_N-1:0]   used_d;
    logic                low_q;
    logic                err_uflow_q;
    logic                err_oflow_q;
    logic                err_dbl_q;

    logic                run;
    logic                alloc_vld;
    logic [PTR_W-1:0]    alloc_ptr;
    logic                alloc_ok;
    logic                full;
    logic                uflow_ev;
    logic                oflow_ev;
    logic                dbl_ev;
    logic                free_ok;

    always_comb begin
        run       = (state_q == ST_RUN);
        alloc_vld = run && (count_q != '0);
        alloc_ptr = fifo_q[rd_idx_q];
        alloc_ok  = alloc_vld && i_alloc_ack;
        uflow_ev  = run && i_alloc_ack && !alloc_vld;
        // Fullness is judged on the count before this cycle's allocation.
        full      = (count_q == FULL_CNT);
        oflow_ev  = run && i_free_vld && full;
        // used_q reflects status before this cycle, so freeing the pointer
        // being allocated right now is correctly seen as a double free.
        dbl_ev    = run && i_free_vld && !full && !used_q[i_free_ptr];
        free_ok   = run && i_free_vld && !full && used_q[i_free_ptr];
    end

    always_comb begin
        count_d = count_q;
        used_d  = used_q;
        if (!run) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else begin
            count_d = count_q + (PTR_W + 1)'(free_ok) - (PTR_W + 1)'(alloc_ok);
            if (alloc_ok) begin
                used_d[alloc_ptr] = 1'b1;
            end
            if (free_ok) begin
                used_d[i_free_ptr] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= ST_INIT;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            init_idx_q  <= '0;
            count_q     <= '0;
            used_q      <= '0;
            low_q       <= 1'b1;
            err_uflow_q <= 1'b0;
            err_oflow_q <= 1'b0;
            err_dbl_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            used_q  <= used_d;
            low_q   <= (count_d < LOW_CNT);
            case (state_q)
                ST_INIT: begin
                    fifo_q[wr_idx_q] <= init_idx_q;
                    wr_idx_q         <= wr_idx_q + PTR_W'(1);
                    init_idx_q       <= init_idx_q + PTR_W'(1);
                    if (init_idx_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (alloc_ok) begin
                        rd_idx_q <= rd_idx_q + PTR_W'(1);
                    end
                    if (free_ok) begin
                        fifo_q[wr_idx_q] <= i_free_ptr;
                        wr_idx_q         <= wr_idx_q + PTR_W'(1);
                    end
                    if (uflow_ev) err_uflow_q <= 1'b1;
                    if (oflow_ev) err_oflow_q <= 1'b1;
                    if (dbl_ev)   err_dbl_q   <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy         = !run;
    assign o_alloc_vld    = alloc_vld;
    assign o_alloc_ptr    = alloc_ptr;
    assign o_free_cnt     = count_q;
    assign o_low          = low_q;
    assign o_err_uflow    = err_uflow_q;
    assign o_err_oflow    = err_oflow_q;
    assign o_err_dbl_free = err_dbl_q;

endmodule
